sftctl: RTL and testbench
=========================

# sftctl

Shift-sequence controller for the lites address shifter. It generates the `sftbynum`/`sftbymax` pair consumed by `sftbyn`, advancing the shift once every N frames in forward, reverse or bounce mode. All changes occur only at frame boundaries, so a strand refresh never sees a mid-frame shift. New configuration arrives through a shadow-register load that takes effect at the next frame boundary.

## Interface

Parameters
- `RATE_W`, 8, width of the frames-per-step divider.

Ports
- `clk8`  in  1  system clock.
- `reset8_n`  in  1  asynchronous, active-low reset.
- `frame_end`  in  1  one-cycle pulse, last cycle of a strand refresh.
- `pause`  in  1  level; holds the current shift and freezes the divider.
- `cfg_load`  in  1  one-cycle pulse; captures `cfg_*` into shadow registers.
- `cfg_mode`  in  2  0 = off, 1 = forward, 2 = reverse, 3 = bounce.
- `cfg_rate`  in  RATE_W  step every `cfg_rate+1` frames.
- `cfg_max`  in  6  shift modulus, 0..63.
- `cfg_ack`  out  1  one-cycle pulse; shadow config now active.
- `sftbynum`  out  8  current shift, `{2'b00, num[5:0]}`.
- `sftbymax`  out  8  active modulus, `{2'b00, max[5:0]}`.
- `step`  out  1  one-cycle pulse when `sftbynum` changed by a step.

## Operation

- Reset (`reset8_n`=0, asynchronous): mode=off, num=0, max=0, rate=0, divider=0, dir=up, pending=0. All outputs are 0.
- `cfg_load`: writes the shadow registers and sets `pending`. A second load before apply overwrites the shadow; `pending` stays 1.
- Apply: on a `frame_end` with `pending`=1, shadow moves to active, num=0, divider=0, dir=up, and `pending` clears. No step occurs on that frame. Apply takes priority over `pause`.
- `cfg_load` and `frame_end` in the same cycle: the load goes to the shadow. If `pending` was already 1, the *old* shadow is applied. In either case the new values are applied at the following `frame_end`.
- Divider: on each `frame_end` with no apply, `pause`=0 and mode≠off:
  - If divider==rate, then divider=0 and a step occurs.
  - Otherwise divider increments.
- Step arithmetic is 6-bit. The effective modulus is `m = max`. If max ≤ 1, num stays 0 and `step` is not asserted.
  - forward: num = (num+1 == m) ? 0 : num+1
  - reverse: num = (num == 0) ? m-1 : num-1
  - bounce, dir=up: when num+1 == m-1, num = num+1 and dir=down; otherwise num = num+1.
  - bounce, dir=down: when num-1 == 0, num = 0 and dir=up; otherwise num = num-1.
  - For bounce with m=2, the sequence is 0,1,0,1…
- mode=off: num is held at 0 and the divider is held at 0.
- States: `S_OFF`, `S_RUN`, `S_PAUSE`.
  - The active mode selects `S_OFF` or `S_RUN`.
  - `pause`=1 moves `S_RUN` to `S_PAUSE`; `pause`=0 returns it to `S_RUN`.
  - An apply re-enters `S_OFF` or `S_RUN` according to the new mode.

## Timing

- All outputs are registered.
- `sftbynum`, `sftbymax` and `step` update on the clock edge that samples `frame_end`. They are visible the cycle after `frame_end`.
- `cfg_ack` is asserted the cycle after the applying `frame_end`, in the same cycle the new `sftbymax` appears.
- Between `frame_end` pulses, `sftbynum` and `sftbymax` are constant.
- `frame_end` pulses 1 cycle apart are legal; each one is counted.
- Deasserting `reset8_n` mid-frame returns all state to reset values immediately. Operation resumes at the next `frame_end` only if a `cfg_load` was accepted after reset.

## Structure

- Shared package `dazz_pkg`:
  - `MODE_OFF/FWD/REV/BNC` 2-bit constants.
  - `SFT_W` = 6.
  - State encodings `S_OFF/S_RUN/S_PAUSE`.
- Sub-module `sft_ratediv`: RATE_W frame divider.
  - Inputs: `frame_end`, `en`, `clr`, `rate`.
  - Output: `tick`.
  - `tick` is combinational, qualified by `frame_end`.
- The step arithmetic and shadow/apply logic stay in `sftctl`.

## Test plan

- Reset, then cfg_load(mode=fwd, rate=0, max=5), then 7 `frame_end` pulses:
  - 1st `frame_end`: `cfg_ack` pulses, sftbynum=0, sftbymax=5.
  - Following pulses: sftbynum = 1,2,3,4,0,1; `step` pulses 6 times.
- Reverse with rate=2, max=4: sftbynum steps every 3rd frame, 0→3→2→1→0.
- Bounce with max=4: sequence 0,1,2,3,2,1,0,1. With max=1, sftbynum=0 always and `step` never pulses.
- `pause` high across 4 frames mid-run: sftbynum frozen and divider frozen. Resumes at the exact divider phase.
- Two cfg_loads (max=8, then max=3) before a frame: only max=3 is applied, with a single `cfg_ack`. Repeat with `cfg_load` coincident with `frame_end`: apply is deferred one frame.
- Assert `reset8_n`=0 mid-run at sftbynum=4: outputs read 0 within the same cycle, asynchronously. Later `frame_end` pulses leave outputs at 0 until a new cfg_load.

Source files
------------

// File: rtl/dazz_pkg.sv
// Shared constants for the lites shift controller: mode codes, shift width
// and controller state encodings.
package dazz_pkg;

    localparam int SFT_W = 6;

    localparam logic [1:0] MODE_OFF = 2'd0;
    localparam logic [1:0] MODE_FWD = 2'd1;
    localparam logic [1:0] MODE_REV = 2'd2;
    localparam logic [1:0] MODE_BNC = 2'd3;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } sft_state_e;

endpackage

// File: rtl/sft_ratediv.sv
// Frame divider: counts frame_end pulses and ticks on the frame where the
// count reaches rate, so a tick lands every rate+1 counted frames.
module sft_ratediv #(
    parameter int RATE_W = 8
) (
    input  logic              clk8,
    input  logic              reset8_n,
    input  logic              frame_end,
    input  logic              en,
    input  logic              clr,
    input  logic [RATE_W-1:0] rate,
    output logic              tick
);

    logic [RATE_W-1:0] cnt_q;

    assign tick = frame_end & en & (cnt_q == rate);

    always_ff @(posedge clk8 or negedge reset8_n) begin
        if (!reset8_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (frame_end && en) begin
            cnt_q <= tick ? '0 : cnt_q + RATE_W'(1);
        end
    end

endmodule

// File: rtl/sftctl.sv
// Shift-sequence controller: produces sftbynum/sftbymax for sftbyn, stepping
// once every rate+1 frames; config is shadowed and applied on a frame boundary.
//
//   state   | meaning
//   S_OFF   | active mode is off; num and divider held at 0
//   S_RUN   | divider counts frames, num steps on divider tick
//   S_PAUSE | pause held; num and divider frozen
module sftctl
    import dazz_pkg::*;
#(
    parameter int RATE_W = 8
) (
    input  logic              clk8,
    input  logic              reset8_n,
    input  logic              frame_end,
    input  logic              pause,
    input  logic              cfg_load,
    input  logic [1:0]        cfg_mode,
    input  logic [RATE_W-1:0] cfg_rate,
    input  logic [5:0]        cfg_max,
    output logic              cfg_ack,
    output logic [7:0]        sftbynum,
    output logic [7:0]        sftbymax,
    output logic              step
);

    sft_state_e        state_q, state_d;
    logic [1:0]        shd_mode_q, mode_q;
    logic [RATE_W-1:0] shd_rate_q, rate_q;
    logic [SFT_W-1:0]  shd_max_q, max_q;
    logic [SFT_W-1:0]  num_q, num_d, num_inc, num_dec;
    logic              dir_q, dir_d;
    logic              pend_q, step_q, step_d, ack_q;
    logic              apply, div_en, div_clr, tick;

    // A pending shadow always wins over pause on a frame boundary.
    assign apply   = frame_end & pend_q;
    assign div_en  = ~apply & ~pause & (state_q != S_OFF);
    assign div_clr = apply | (state_q == S_OFF);

    sft_ratediv #(.RATE_W(RATE_W)) u_ratediv (
        .clk8      (clk8),
        .reset8_n  (reset8_n),
        .frame_end (frame_end),
        .en        (div_en),
        .clr       (div_clr),
        .rate      (rate_q),
        .tick      (tick)
    );

    always_ff @(posedge clk8 or negedge reset8_n) begin
        if (!reset8_n) begin
            state_q <= S_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (apply) begin
            state_d = (shd_mode_q == MODE_OFF) ? S_OFF : S_RUN;
        end else begin
            case (state_q)
                S_RUN:   if (pause)  state_d = S_PAUSE;
                S_PAUSE: if (!pause) state_d = S_RUN;
                default: state_d = S_OFF;
            endcase
        end
    end

    always_comb begin
        num_inc = num_q + 6'd1;
        num_dec = num_q - 6'd1;
        num_d   = num_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        if (apply) begin
            num_d = '0;
            dir_d = 1'b0;
        end else if (tick && (max_q > 6'd1)) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_FWD: num_d = (num_inc == max_q) ? '0 : num_inc;
                MODE_REV: num_d = (num_q == '0) ? (max_q - 6'd1) : num_dec;
                MODE_BNC: begin
                    if (!dir_q) begin
                        num_d = num_inc;
                        if (num_inc == (max_q - 6'd1)) dir_d = 1'b1;
                    end else begin
                        num_d = num_dec;
                        if (num_dec == '0) dir_d = 1'b0;
                    end
                end
                default: step_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk8 or negedge reset8_n) begin
        if (!reset8_n) begin
            shd_mode_q <= MODE_OFF;
            shd_rate_q <= '0;
            shd_max_q  <= '0;
            pend_q     <= 1'b0;
            mode_q     <= MODE_OFF;
            rate_q     <= '0;
            max_q      <= '0;
            num_q      <= '0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            num_q  <= num_d;
            dir_q  <= dir_d;
            step_q <= step_d;
            ack_q  <= apply;
            // On a coincident load the old shadow is applied and the new one waits.
            if (apply) begin
                mode_q <= shd_mode_q;
                rate_q <= shd_rate_q;
                max_q  <= shd_max_q;
            end
            if (cfg_load) begin
                shd_mode_q <= cfg_mode;
                shd_rate_q <= cfg_rate;
                shd_max_q  <= cfg_max;
            end
            pend_q <= cfg_load | (pend_q & ~frame_end);
        end
    end

    assign sftbynum = {2'b00, num_q};
    assign sftbymax = {2'b00, max_q};
    assign step     = step_q;
    assign cfg_ack  = ack_q;

endmodule

// File: tb/tb_sftctl.sv
// Vector-table bench for sftctl with a scoreboard queue of expected outputs.
module tb_sftctl;

    logic       clk8 = 1'b0;
    logic       reset8_n = 1'b0;
    logic       frame_end = 1'b0;
    logic       pause = 1'b0;
    logic       cfg_load = 1'b0;
    logic [1:0] cfg_mode = 2'd0;
    logic [7:0] cfg_rate = 8'd0;
    logic [5:0] cfg_max = 6'd0;
    logic       cfg_ack;
    logic [7:0] sftbynum;
    logic [7:0] sftbymax;
    logic       step;

    int checks = 0;
    int errors = 0;
    int cur = 0;

    typedef struct {
        logic       fe, ld, ps;
        logic [1:0] mode;
        logic [7:0] rate;
        logic [5:0] max;
        logic [7:0] e_num, e_max;
        logic       e_step, e_ack;
    } vec_t;

    typedef struct {
        logic [7:0] num, max;
        logic       step, ack;
    } exp_t;

    vec_t vecs[$];
    vec_t vecs2[$];
    exp_t sb[$];

    sftctl #(.RATE_W(8)) dut (
        .clk8      (clk8),
        .reset8_n  (reset8_n),
        .frame_end (frame_end),
        .pause     (pause),
        .cfg_load  (cfg_load),
        .cfg_mode  (cfg_mode),
        .cfg_rate  (cfg_rate),
        .cfg_max   (cfg_max),
        .cfg_ack   (cfg_ack),
        .sftbynum  (sftbynum),
        .sftbymax  (sftbymax),
        .step      (step)
    );

    always #5 clk8 = ~clk8;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic fe, logic ld, logic ps, logic [1:0] md,
                                logic [7:0] rt, logic [5:0] mx, logic [7:0] en,
                                logic [7:0] em, logic es, logic ea);
        vec_t v;
        v.fe = fe; v.ld = ld; v.ps = ps; v.mode = md; v.rate = rt; v.max = mx;
        v.e_num = en; v.e_max = em; v.e_step = es; v.e_ack = ea;
        return v;
    endfunction

    function automatic vec_t fr(logic [7:0] en, logic [7:0] em, logic es, logic ea);
        return mk(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 6'd0, en, em, es, ea);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, cur, act, exp_v);
        end
    endtask

    task automatic score();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard vec %0d: got empty queue expected an entry", cur);
        end else begin
            e = sb.pop_front();
            chk("sftbynum", sftbynum, e.num);
            chk("sftbymax", sftbymax, e.max);
            chk("step", {7'd0, step}, {7'd0, e.step});
            chk("cfg_ack", {7'd0, cfg_ack}, {7'd0, e.ack});
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk8);
        frame_end = v.fe;
        cfg_load  = v.ld;
        pause     = v.ps;
        cfg_mode  = v.mode;
        cfg_rate  = v.rate;
        cfg_max   = v.max;
        e.num = v.e_num; e.max = v.e_max; e.step = v.e_step; e.ack = v.e_ack;
        sb.push_back(e);
        @(posedge clk8);
        #1;
        frame_end = 1'b0;
        cfg_load  = 1'b0;
        score();
        cur++;
    endtask

    initial begin
        // forward, rate 0, max 5
        vecs.push_back(mk(0, 1, 0, 2'd1, 8'd0, 6'd5, 0, 0, 0, 0));
        vecs.push_back(fr(0, 5, 0, 1));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'd0, 6'd0, 0, 5, 0, 0));
        vecs.push_back(fr(1, 5, 1, 0));
        vecs.push_back(fr(2, 5, 1, 0));
        vecs.push_back(fr(3, 5, 1, 0));
        vecs.push_back(fr(4, 5, 1, 0));
        vecs.push_back(fr(0, 5, 1, 0));
        vecs.push_back(fr(1, 5, 1, 0));
        // reverse, rate 2, max 4
        vecs.push_back(mk(0, 1, 0, 2'd2, 8'd2, 6'd4, 1, 5, 0, 0));
        vecs.push_back(fr(0, 4, 0, 1));
        vecs.push_back(fr(0, 4, 0, 0));
        vecs.push_back(fr(0, 4, 0, 0));
        vecs.push_back(fr(3, 4, 1, 0));
        vecs.push_back(fr(3, 4, 0, 0));
        vecs.push_back(fr(3, 4, 0, 0));
        vecs.push_back(fr(2, 4, 1, 0));
        vecs.push_back(fr(2, 4, 0, 0));
        vecs.push_back(fr(2, 4, 0, 0));
        vecs.push_back(fr(1, 4, 1, 0));
        vecs.push_back(fr(1, 4, 0, 0));
        vecs.push_back(fr(1, 4, 0, 0));
        vecs.push_back(fr(0, 4, 1, 0));
        // bounce, max 4
        vecs.push_back(mk(0, 1, 0, 2'd3, 8'd0, 6'd4, 0, 4, 0, 0));
        vecs.push_back(fr(0, 4, 0, 1));
        vecs.push_back(fr(1, 4, 1, 0));
        vecs.push_back(fr(2, 4, 1, 0));
        vecs.push_back(fr(3, 4, 1, 0));
        vecs.push_back(fr(2, 4, 1, 0));
        vecs.push_back(fr(1, 4, 1, 0));
        vecs.push_back(fr(0, 4, 1, 0));
        vecs.push_back(fr(1, 4, 1, 0));
        // bounce, max 1: never steps
        vecs.push_back(mk(0, 1, 0, 2'd3, 8'd0, 6'd1, 1, 4, 0, 0));
        vecs.push_back(fr(0, 1, 0, 1));
        vecs.push_back(fr(0, 1, 0, 0));
        vecs.push_back(fr(0, 1, 0, 0));
        vecs.push_back(fr(0, 1, 0, 0));
        // forward rate 2 with pause across 4 frames at divider phase 1
        vecs.push_back(mk(0, 1, 0, 2'd1, 8'd2, 6'd8, 0, 1, 0, 0));
        vecs.push_back(fr(0, 8, 0, 1));
        vecs.push_back(fr(0, 8, 0, 0));
        vecs.push_back(mk(0, 0, 1, 2'd0, 8'd0, 6'd0, 0, 8, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 1, 2'd0, 8'd0, 6'd0, 0, 8, 0, 0));
        vecs.push_back(fr(0, 8, 0, 0));
        vecs.push_back(fr(1, 8, 1, 0));
        vecs.push_back(fr(1, 8, 0, 0));
        // two loads before a frame: only the last is applied
        vecs.push_back(mk(0, 1, 0, 2'd1, 8'd0, 6'd8, 1, 8, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd1, 8'd0, 6'd3, 1, 8, 0, 0));
        vecs.push_back(fr(0, 3, 0, 1));
        vecs.push_back(fr(1, 3, 1, 0));
        vecs.push_back(fr(2, 3, 1, 0));
        vecs.push_back(fr(0, 3, 1, 0));
        // load coincident with frame_end, pending set: old shadow applied first
        vecs.push_back(mk(0, 1, 0, 2'd1, 8'd0, 6'd5, 0, 3, 0, 0));
        vecs.push_back(mk(1, 1, 0, 2'd1, 8'd0, 6'd6, 0, 5, 0, 1));
        vecs.push_back(fr(0, 6, 0, 1));
        vecs.push_back(fr(1, 6, 1, 0));
        // load coincident with frame_end, no pending: normal step, apply deferred
        vecs.push_back(mk(1, 1, 0, 2'd2, 8'd0, 6'd4, 2, 6, 1, 0));
        vecs.push_back(fr(0, 4, 0, 1));
        vecs.push_back(fr(3, 4, 1, 0));
        vecs.push_back(fr(2, 4, 1, 0));
        // run forward to num 4 ahead of the reset
        vecs.push_back(mk(0, 1, 0, 2'd1, 8'd0, 6'd6, 2, 4, 0, 0));
        vecs.push_back(fr(0, 6, 0, 1));
        vecs.push_back(fr(1, 6, 1, 0));
        vecs.push_back(fr(2, 6, 1, 0));
        vecs.push_back(fr(3, 6, 1, 0));
        vecs.push_back(fr(4, 6, 1, 0));

        // after reset: frames do nothing until a load is accepted
        vecs2.push_back(fr(0, 0, 0, 0));
        vecs2.push_back(fr(0, 0, 0, 0));
        vecs2.push_back(fr(0, 0, 0, 0));
        vecs2.push_back(mk(1, 1, 0, 2'd1, 8'd0, 6'd5, 0, 0, 0, 0));
        vecs2.push_back(fr(0, 5, 0, 1));
        vecs2.push_back(fr(1, 5, 1, 0));

        // reset state
        #12;
        chk("reset_num", sftbynum, 8'd0);
        chk("reset_max", sftbymax, 8'd0);
        chk("reset_step", {7'd0, step}, 8'd0);
        chk("reset_ack", {7'd0, cfg_ack}, 8'd0);
        @(negedge clk8);
        reset8_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // asynchronous reset mid-frame, observed before the next clock edge
        @(negedge clk8);
        #2;
        reset8_n = 1'b0;
        #1;
        chk("async_num", sftbynum, 8'd0);
        chk("async_max", sftbymax, 8'd0);
        chk("async_step", {7'd0, step}, 8'd0);
        chk("async_ack", {7'd0, cfg_ack}, 8'd0);
        @(negedge clk8);
        reset8_n = 1'b1;

        foreach (vecs2[i]) run_vec(vecs2[i]);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d leftover entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
